// File: rtl/core_mdu_seq_if.sv
// Handshake and result bus between the EX stage and the MUL/DIV sequencer.
interface core_mdu_seq_if #(
  parameter int unsigned DW = 32
);
  logic          start;
  logic          op_div;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic          flush;
  logic          halt_req;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          div_zero;

  modport master (
    output start, op_div, opa, opb, flush,
    input  halt_req, busy, done, result, div_zero
  );

  modport slave (
    input  start, op_div, opa, opb, flush,
    output halt_req, busy, done, result, div_zero
  );
endinterface

// File: rtl/core_mdu_seq.sv
// Iterative MUL/DIV sequencer for the EX stage: shift-add multiply and restoring
// divide at one bit per cycle, stalling EX via halt_req until the DONE cycle.
module core_mdu_seq #(
  parameter int unsigned DW = 32
) (
  input  logic           clk,
  input  logic           rst,
  core_mdu_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_div_q, op_div_d;
  // a: multiplicand / dividend shifting out, quotient bits shifting in
  // b: multiplier / divisor;  acc: product accumulator / DW+1 bit remainder
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW:0]   acc_q, acc_d;
  logic [DW-1:0] result_q, result_d;
  logic          done_q, done_d;
  logic          div_zero_q, div_zero_d;
  logic [DW:0]   rem_sh;
  logic [DW-1:0] sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_div_q   <= op_div_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Next state, datapath step and registered done/div_zero (high only in DONE).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_div_d   = op_div_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    rem_sh     = '0;
    sum        = '0;

    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_div_d = bus.op_div;
            a_d      = bus.opa;
            b_d      = bus.opb;
            acc_d    = '0;
            cnt_d    = '0;
            if (bus.op_div && (bus.opb == '0)) begin
              state_d    = S_DONE;
              result_d   = '1;
              done_d     = 1'b1;
              div_zero_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          cnt_d = cnt_q + CW'(1);
          if (op_div_q) begin
            rem_sh = {acc_q[DW-1:0], a_q[DW-1]};
            if (rem_sh >= {1'b0, b_q}) begin
              acc_d = rem_sh - {1'b0, b_q};
              a_d   = {a_q[DW-2:0], 1'b1};
            end else begin
              acc_d = rem_sh;
              a_d   = {a_q[DW-2:0], 1'b0};
            end
          end else begin
            sum   = acc_q[DW-1:0] + ({DW{b_q[0]}} & a_q);
            acc_d = {1'b0, sum};
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
          end
          if (cnt_q == CW'(DW - 1)) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = op_div_q ? a_d : acc_d[DW-1:0];
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stall is raised the very cycle start is seen and dropped in DONE so EX can retire.
  assign bus.halt_req = rst & bus.start & ~bus.flush & (state_q != S_DONE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_core_mdu_seq.sv
// Self-checking bench for core_mdu_seq: directed vector table, random ops against
// an arithmetic reference model, and flush / back-to-back / reset sequences.
module tb_core_mdu_seq;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   passed;

  core_mdu_seq_if #(.DW(DW)) bus ();

  core_mdu_seq #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            div;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp_res;
    bit            exp_dz;
    int            exp_cyc;
  } vec_t;

  vec_t vecs[8];

  // observations of the most recent run_op
  logic [DW-1:0] r_res;
  bit            r_dz;
  int            r_done_cyc;
  int            r_halts;
  int            r_done_abs;
  bit            r_halt_done;
  bit            r_halt_flush;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [DW-1:0] model(input bit div, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    longint unsigned p;
    if (div) return (b == '0) ? '1 : a / b;
    p = 64'(a) * 64'(b);
    return p[DW-1:0];
  endfunction

  // Present one instruction in EX starting this cycle; holds start until done or flush.
  task run_op(input bit div, input logic [DW-1:0] a, input logic [DW-1:0] b, input int flush_at);
    bit seen;
    seen = 1'b0;
    r_done_cyc = -1; r_halts = 0; r_halt_done = 1'b0; r_halt_flush = 1'b1;
    for (int c = 0; c < int'(DW) + 8 && !seen; c++) begin
      if (c == 0) begin
        bus.start = 1'b1; bus.op_div = div; bus.opa = a; bus.opb = b;
      end else begin
        bus.opa = $urandom; bus.opb = $urandom; bus.op_div = 1'($urandom);
      end
      bus.flush = (c == flush_at);
      #1;
      if (bus.halt_req) r_halts++;
      if (c == flush_at) r_halt_flush = bus.halt_req;
      if (bus.done) begin
        seen = 1'b1; r_done_cyc = c; r_res = bus.result; r_dz = bus.div_zero;
        r_done_abs = cyc; r_halt_done = bus.halt_req;
      end
      @(posedge clk); #1;
      if (c == flush_at) begin
        bus.flush = 1'b0; bus.start = 1'b0;
        break;
      end
    end
  endtask

  task idle();
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("done_pulse_width", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
  endtask

  task check_op(input string tag, input logic [DW-1:0] er, input bit edz, input int ecyc);
    chk({tag, "_result"},   64'(r_res), 64'(er));
    chk({tag, "_div_zero"}, 64'(r_dz), 64'(edz));
    chk({tag, "_done_cyc"}, 64'(r_done_cyc), 64'(ecyc));
    chk({tag, "_halts"},    64'(r_halts), 64'(ecyc));
    chk({tag, "_halt_in_done"}, 64'(r_halt_done), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] res1;
    int            abs1;
    bit            any_done;

    total = 0; passed = 0;
    vecs[0] = '{0, 32'd7,          32'd6,          32'd42,         0, 33};
    vecs[1] = '{0, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  0, 33};
    vecs[2] = '{0, 32'h0001_0000,  32'h0001_0000,  32'd0,          0, 33};
    vecs[3] = '{1, 32'd100,        32'd7,          32'd14,         0, 33};
    vecs[4] = '{1, 32'd5,          32'd9,          32'd0,          0, 33};
    vecs[5] = '{1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  0, 33};
    vecs[6] = '{1, 32'd8,          32'd0,          32'hFFFF_FFFF,  1, 1};
    vecs[7] = '{1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          0, 33};

    rst = 1'b0;
    bus.start = 1'b0; bus.op_div = 1'b0; bus.opa = '0; bus.opb = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result",   64'(bus.result), 64'd0);
    chk("rst_done",     64'(bus.done), 64'd0);
    chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
    chk("rst_busy",     64'(bus.busy), 64'd0);
    chk("rst_halt",     64'(bus.halt_req), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].div, vecs[i].a, vecs[i].b, -1);
      check_op($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_dz, vecs[i].exp_cyc);
      idle();
    end

    for (int n = 0; n < 24; n++) begin
      bit            d;
      logic [DW-1:0] a, b;
      d = 1'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = DW'($urandom_range(1, 300));
        1: b = '0;
        2: a = '1;
        default: ;
      endcase
      run_op(d, a, b, -1);
      check_op($sformatf("rnd%0d", n), model(d, a, b), d && (b == '0),
               (d && (b == '0)) ? 1 : int'(DW) + 1);
      idle();
    end

    // Flush mid-multiply: no done, result untouched, then a normal op
    run_op(0, 32'd5, 32'd7, -1);
    chk("pre_flush_result", 64'(r_res), 64'd35);
    idle();
    run_op(0, 32'hABCD, 32'h1234, 10);
    chk("flush_halt_same_cycle", 64'(r_halt_flush), 64'd0);
    chk("flush_halts_before", 64'(r_halts), 64'd10);
    #1;
    chk("flush_busy_next", 64'(bus.busy), 64'd0);
    chk("flush_result_kept", 64'(bus.result), 64'd35);
    any_done = (r_done_cyc != -1);
    for (int k = 0; k < 40; k++) begin
      if (bus.done) any_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_done", 64'(any_done), 64'd0);
    run_op(0, 32'd3, 32'd3, -1);
    check_op("post_flush", 32'd9, 0, 33);
    idle();

    // Back-to-back: DIV enters EX the cycle after the MUL's DONE
    run_op(0, 32'd2, 32'd3, -1);
    res1 = r_res; abs1 = r_done_abs;
    run_op(1, 32'd9, 32'd3, -1);
    chk("b2b_first",   64'(res1), 64'd6);
    chk("b2b_second",  64'(r_res), 64'd3);
    chk("b2b_spacing", 64'(r_done_abs - abs1), 64'd34);
    idle();

    // Asynchronous reset in the middle of a run
    bus.start = 1'b1; bus.op_div = 1'b0; bus.opa = 32'd7; bus.opb = 32'd6; bus.flush = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    chk("midrun_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    #1;
    chk("arst_halt",     64'(bus.halt_req), 64'd0);
    chk("arst_busy",     64'(bus.busy), 64'd0);
    chk("arst_done",     64'(bus.done), 64'd0);
    chk("arst_result",   64'(bus.result), 64'd0);
    chk("arst_div_zero", 64'(bus.div_zero), 64'd0);
    bus.start = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
